// File: rtl/lab_pkg.sv
// Shared constants for the digit-serial adder sequencer.
//   DIGIT_W              width of one operand digit
//   IDLE/ADD/CARRY/DONE  sequencer state encoding
package lab_pkg;

  localparam int unsigned DIGIT_W = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADD   = 2'd1;
  localparam logic [1:0] CARRY = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/digit_serial_add_ctrl.sv
// Digit-serial sequencer computing a WIDTH-bit + WIDTH-bit unsigned sum with one
// external 2-bit adder. Each digit takes two cycles: ADD sums the operand digits,
// CARRY folds the stored carry into the partial digit.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, a, b     request and operands, accepted in IDLE or DONE
//   busy            high while in ADD or CARRY
//   done            one-cycle pulse, sum valid
//   sum             WIDTH+1-bit result (carry-out in MSB), held until next start
//   add_a, add_b    operands driven to the external 2-bit adder
//   add_s           combinational result returned by the adder
module digit_serial_add_ctrl
  import lab_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output logic [1:0]       add_a,
  output logic [1:0]       add_b,
  input  logic [3:0]       add_s
);

  localparam int unsigned NDIG = WIDTH / 2;
  localparam int unsigned CntW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((WIDTH % 2) != 0 || WIDTH < 2) begin : gen_width_check
    $error("digit_serial_add_ctrl: WIDTH must be even and >= 2");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q;
  logic [1:0]       part_q;
  logic             c1_q, cin_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   sum_q;

  logic [1:0]       digit;
  logic             cout;
  logic             last;
  logic [WIDTH-1:0] acc_next;
  logic             unused_add_s3;

  // Adder guarantees the top bit is zero for 2-bit operands.
  assign unused_add_s3 = add_s[3];

  assign digit = add_s[1:0];
  // c1 and the carry-phase carry are mutually exclusive, so OR is the true carry.
  assign cout  = c1_q | add_s[2];
  assign last  = (cnt_q == CntW'(NDIG - 1));
  // Shift the new digit in at the top; written as a shift so WIDTH=2 elaborates.
  assign acc_next = WIDTH'({digit, acc_q} >> DIGIT_W);

  always_comb begin
    add_a = 2'b00;
    add_b = 2'b00;
    unique case (state_q)
      ADD: begin
        add_a = opa_q[1:0];
        add_b = opb_q[1:0];
      end
      CARRY: begin
        add_a = part_q;
        add_b = {1'b0, cin_q};
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     state_d = CARRY;
      CARRY:   state_d = last ? DONE : ADD;
      DONE:    state_d = start ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      part_q  <= '0;
      c1_q    <= 1'b0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            opa_q <= a;
            opb_q <= b;
            acc_q <= '0;
            cin_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        ADD: begin
          part_q <= add_s[1:0];
          c1_q   <= add_s[2];
        end
        CARRY: begin
          cin_q <= cout;
          acc_q <= acc_next;
          opa_q <= opa_q >> DIGIT_W;
          opb_q <= opb_q >> DIGIT_W;
          cnt_q <= cnt_q + CntW'(1);
          if (last) sum_q <= {cout, acc_next};
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q == ADD) || (state_q == CARRY);
  assign done = (state_q == DONE);
  assign sum  = sum_q;

endmodule

// File: tb/tb_digit_serial_add_ctrl.sv
module tb_digit_serial_add_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NDIG  = WIDTH / 2;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done;
  logic [WIDTH:0]   sum;
  logic [1:0]       add_a, add_b;
  logic [3:0]       add_s;

  int vectors;
  int miscompares;

  // Stand-in for the shared 2-bit adder instance.
  assign add_s = {2'b00, add_a} + {2'b00, add_b};

  digit_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .add_a (add_a),
    .add_b (add_b),
    .add_s (add_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Call #1 after a clock edge; the next edge accepts the request.
  task automatic start_op(input int ea, input int eb);
    start = 1'b1;
    a     = WIDTH'(ea);
    b     = WIDTH'(eb);
  endtask

  // Waits for the accepting edge, then checks every ADD/CARRY cycle against
  // digit arithmetic of ea+eb and finally the DONE cycle. Returns #1 after the
  // edge that entered DONE; optionally requests a chained op in that cycle.
  task automatic run_op(input int ea, input int eb, input bit pulse_mid,
                        input bit chain, input int na, input int nb);
    int ad, bd, cin, mask;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(NDIG); i++) begin
      ad   = (ea >> (2 * i)) & 3;
      bd   = (eb >> (2 * i)) & 3;
      mask = (1 << (2 * i)) - 1;
      cin  = ((ea & mask) + (eb & mask)) >> (2 * i);
      if (pulse_mid && i == 1) start_op(1, 1);
      chk("busy_add", int'(busy), 1);
      chk("add_a_add", int'(add_a), ad);
      chk("add_b_add", int'(add_b), bd);
      @(posedge clk); #1;
      if (pulse_mid && i == 1) start = 1'b0;
      chk("busy_carry", int'(busy), 1);
      chk("done_busy", int'(done), 0);
      chk("add_a_carry", int'(add_a), (ad + bd) % 4);
      chk("add_b_carry", int'(add_b), cin);
      @(posedge clk); #1;
    end
    chk("done_pulse", int'(done), 1);
    chk("busy_done", int'(busy), 0);
    chk("sum", int'(sum), ea + eb);
    chk("add_a_done", int'(add_a), 0);
    if (chain) start_op(na, nb);
  endtask

  task automatic finish_idle(input int exp_sum);
    @(posedge clk); #1;
    chk("done_low", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("sum_hold", int'(sum), exp_sum);
  endtask

  initial begin
    int ra, rb;
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_add_a", int'(add_a), 0);
    chk("rst_add_b", int'(add_b), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases.
    start_op(8'h00, 8'h00); run_op(8'h00, 8'h00, 0, 0, 0, 0); finish_idle(9'h000);
    start_op(8'hFF, 8'h01); run_op(8'hFF, 8'h01, 0, 0, 0, 0); finish_idle(9'h100);
    start_op(8'hAA, 8'h55); run_op(8'hAA, 8'h55, 0, 0, 0, 0); finish_idle(9'h0FF);
    start_op(8'hFF, 8'hFF); run_op(8'hFF, 8'hFF, 0, 0, 0, 0); finish_idle(9'h1FE);

    // Mid-operation start ignored, then back-to-back start from DONE.
    start_op(8'h1B, 8'h27);
    run_op(8'h1B, 8'h27, 1, 1, 8'h01, 8'h01);
    run_op(8'h01, 8'h01, 0, 0, 0, 0);
    finish_idle(9'h002);

    // Reset during operation aborts without a done pulse.
    start_op(8'hFF, 8'h01);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sum", int'(sum), 0);
    chk("abort_done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", int'(done), 0);
    end
    start_op(8'h12, 8'h34); run_op(8'h12, 8'h34, 0, 0, 0, 0); finish_idle(9'h046);

    // Random operands, some chained back-to-back.
    ra = int'($urandom_range(0, 255));
    rb = int'($urandom_range(0, 255));
    start_op(ra, rb);
    for (int n = 0; n < 24; n++) begin
      int na, nb;
      bit chain;
      na    = int'($urandom_range(0, 255));
      nb    = int'($urandom_range(0, 255));
      chain = ($urandom_range(0, 1) == 1);
      run_op(ra, rb, 0, chain, na, nb);
      if (!chain) begin
        finish_idle(ra + rb);
        start_op(na, nb);
      end
      ra = na;
      rb = nb;
    end
    run_op(ra, rb, 0, 0, 0, 0);
    finish_idle(ra + rb);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
